// File: rtl/ft2232h_rx_if.sv
// FT2232H synchronous 245 FIFO receive engine (PC -> FPGA).
// Drives OE#/RD#, captures bytes on CLKOUT and buffers them in a FWFT byte FIFO.
module ft2232h_rx_if #(
    parameter int AW    = 4,
    parameter int CNT_W = 32
) (
    input  logic             clkout_i,
    input  logic             rst_n_i,
    input  logic [7:0]       data_i,
    input  logic             rxf_n_i,
    output logic             oe_n_o,
    output logic             rd_n_o,
    input  logic             rx_en_i,
    output logic             bus_rx_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [AW:0]      fifo_count_o,
    output logic [CNT_W-1:0] rx_bytes_o
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        OE,
        READ,
        TURN
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic [AW:0]     free_next;
    logic            push;
    logic            pop;
    logic [CNT_W-1:0] rx_bytes;

    // The full guard never fires in practice: READ is left on the edge that fills the FIFO.
    assign push = (state == READ) && !rxf_n_i && (count != DEPTH_C);
    assign pop  = m_ready_i && (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_next = count - (AW + 1)'(1);
        end
        free_next = DEPTH_C - count_next;
    end

    always_ff @(posedge clkout_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_bytes <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                rx_bytes <= rx_bytes + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Bus strobes are registered alongside the state so they change only on CLKOUT.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            oe_n_o   <= 1'b1;
            rd_n_o   <= 1'b1;
            bus_rx_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_en_i && !rxf_n_i && (free_next != '0)) begin
                        state    <= OE;
                        oe_n_o   <= 1'b0;
                        rd_n_o   <= 1'b1;
                        bus_rx_o <= 1'b1;
                    end
                end
                OE: begin
                    if (rxf_n_i || !rx_en_i) begin
                        state    <= TURN;
                        oe_n_o   <= 1'b1;
                        rd_n_o   <= 1'b1;
                        bus_rx_o <= 1'b0;
                    end else begin
                        state    <= READ;
                        oe_n_o   <= 1'b0;
                        rd_n_o   <= 1'b0;
                        bus_rx_o <= 1'b1;
                    end
                end
                READ: begin
                    if (rxf_n_i || !rx_en_i || (free_next == '0)) begin
                        state    <= TURN;
                        oe_n_o   <= 1'b1;
                        rd_n_o   <= 1'b1;
                        bus_rx_o <= 1'b0;
                    end
                end
                TURN: begin
                    state    <= IDLE;
                    oe_n_o   <= 1'b1;
                    rd_n_o   <= 1'b1;
                    bus_rx_o <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    oe_n_o   <= 1'b1;
                    rd_n_o   <= 1'b1;
                    bus_rx_o <= 1'b0;
                end
            endcase
        end
    end

    assign m_data_o     = mem[rd_ptr];
    assign m_valid_o    = (count != '0);
    assign fifo_count_o = count;
    assign rx_bytes_o   = rx_bytes;

endmodule

// File: tb/tb_ft2232h_rx_if.sv
// Directed bench for ft2232h_rx_if: an FT2232H byte source model plus an in-order
// scoreboard of captured bytes checked against the stream output every cycle.
module tb_ft2232h_rx_if;

    localparam int AW    = 4;
    localparam int CNT_W = 6;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       data_i;
    logic             rxf_n_i;
    logic             oe_n_o;
    logic             rd_n_o;
    logic             rx_en_i;
    logic             bus_rx_o;
    logic [7:0]       m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [AW:0]      fifo_count_o;
    logic [CNT_W-1:0] rx_bytes_o;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] pc_q[$];
    logic [7:0] exp_q[$];
    int         total      = 0;
    int         rd_cnt     = 0;
    int         oe_entries = 0;
    bit         toggle_rxf = 1'b0;
    logic       prev_oe    = 1'b1;

    always #5 clk = ~clk;

    ft2232h_rx_if #(
        .AW    (AW),
        .CNT_W (CNT_W)
    ) dut (
        .clkout_i     (clk),
        .rst_n_i      (rst_n),
        .data_i       (data_i),
        .rxf_n_i      (rxf_n_i),
        .oe_n_o       (oe_n_o),
        .rd_n_o       (rd_n_o),
        .rx_en_i      (rx_en_i),
        .bus_rx_o     (bus_rx_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .fifo_count_o (fifo_count_o),
        .rx_bytes_o   (rx_bytes_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: present the source byte, predict capture/pop, advance, then check.
    task automatic tick();
        logic consume;
        logic popping;
        logic [7:0] b;
        logic force_high;
        force_high = toggle_rxf && !rd_n_o && (rd_cnt % 3 == 2);
        if (!rd_n_o) rd_cnt++;
        rxf_n_i = (pc_q.size() == 0) || force_high;
        data_i  = (pc_q.size() != 0) ? pc_q[0] : 8'h00;
        consume = !rd_n_o && !rxf_n_i;
        popping = m_ready_i && (exp_q.size() != 0);
        if (popping) chk("stream_data", {24'h0, m_data_o}, {24'h0, exp_q[0]});
        @(posedge clk);
        #1;
        if (popping) void'(exp_q.pop_front());
        if (consume) begin
            b = pc_q.pop_front();
            exp_q.push_back(b);
            total++;
            if (total == 64) chk("rx_bytes_wrap", 32'(rx_bytes_o), 32'd0);
        end
        chk("fifo_count", 32'(fifo_count_o), 32'(exp_q.size()));
        chk("m_valid", 32'(m_valid_o), 32'(exp_q.size() != 0));
        chk("rx_bytes", 32'(rx_bytes_o), 32'(total % 64));
        chk("bus_rx", 32'(bus_rx_o), 32'(!oe_n_o));
        chk("rd_without_oe", 32'(!rd_n_o && oe_n_o), 32'd0);
        if (prev_oe && !oe_n_o) oe_entries++;
        prev_oe = oe_n_o;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic run_until_done(input string tag, input int limit);
        int n = 0;
        while ((pc_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(pc_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        data_i    = 8'h00;
        rxf_n_i   = 1'b1;
        rx_en_i   = 1'b0;
        m_ready_i = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oe_n", 32'(oe_n_o), 32'd1);
        chk("rst_rd_n", 32'(rd_n_o), 32'd1);
        chk("rst_bus_rx", 32'(bus_rx_o), 32'd0);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_rx_bytes", 32'(rx_bytes_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();

        // Five-byte burst with a ready consumer
        rx_en_i   = 1'b1;
        m_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) pc_q.push_back(8'(i));
        tick();
        chk("t2_oe_first", 32'(oe_n_o), 32'd0);
        chk("t2_rd_still_high", 32'(rd_n_o), 32'd1);
        tick();
        chk("t2_rd_low", 32'(rd_n_o), 32'd0);
        repeat (6) tick();
        chk("t2_turn_oe_n", 32'(oe_n_o), 32'd1);
        chk("t2_turn_rd_n", 32'(rd_n_o), 32'd1);
        chk("t2_rx_bytes", 32'(rx_bytes_o), 32'd5);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        tick();
        chk("t2_idle_oe_n", 32'(oe_n_o), 32'd1);
        settle();

        // Stalled consumer: exactly DEPTH bytes captured, then the rest after ready
        m_ready_i = 1'b0;
        for (int i = 0; i < 40; i++) pc_q.push_back(8'(8'h40 + i));
        repeat (18) tick();
        chk("t3_full_count", 32'(fifo_count_o), 32'(DEPTH));
        chk("t3_rd_high_at_full", 32'(rd_n_o), 32'd1);
        repeat (4) tick();
        chk("t3_no_oe_when_full", 32'(oe_n_o), 32'd1);
        chk("t3_pending", 32'(pc_q.size()), 32'd24);
        m_ready_i = 1'b1;
        run_until_done("t3", 300);
        chk("t3_rx_bytes", 32'(rx_bytes_o), 32'd45);
        settle();

        // RXF# blips high during bursts
        toggle_rxf = 1'b1;
        oe_entries = 0;
        rd_cnt     = 0;
        for (int i = 0; i < 12; i++) pc_q.push_back(8'(8'hA0 + i));
        run_until_done("t4", 300);
        toggle_rxf = 1'b0;
        chk("t4_reentries", 32'(oe_entries >= 2), 32'd1);
        chk("t4_rx_bytes", 32'(rx_bytes_o), 32'd57);
        settle();

        // rx_en_i dropped mid-burst
        for (int i = 0; i < 30; i++) pc_q.push_back(8'(8'h10 + i));
        repeat (5) tick();
        chk("t5_in_read", 32'(rd_n_o), 32'd0);
        rx_en_i = 1'b0;
        tick();
        chk("t5_rd_released", 32'(rd_n_o), 32'd1);
        chk("t5_bus_released", 32'(bus_rx_o), 32'd0);
        chk("t5_kept_bytes", 32'(pc_q.size()), 32'd26);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_oe_disabled", 32'(oe_n_o), 32'd1);
        end
        rx_en_i = 1'b1;
        run_until_done("t5", 300);
        chk("t5_rx_bytes_wrapped", 32'(rx_bytes_o), 32'd23);
        settle();

        // Simultaneous push and pop at count = DEPTH-1
        m_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) pc_q.push_back(8'(8'h80 + i));
        for (int n = 0; n < 100 && pc_q.size() != 0; n++) tick();
        settle();
        chk("t6_preload", 32'(fifo_count_o), 32'd15);
        for (int i = 0; i < 10; i++) pc_q.push_back(8'(8'hC0 + i));
        tick();
        chk("t6_oe_with_one_free", 32'(oe_n_o), 32'd0);
        tick();
        chk("t6_read", 32'(rd_n_o), 32'd0);
        m_ready_i = 1'b1;
        tick();
        chk("t6_count_steady", 32'(fifo_count_o), 32'd15);
        chk("t6_still_read", 32'(rd_n_o), 32'd0);
        tick();
        chk("t6_count_steady2", 32'(fifo_count_o), 32'd15);
        run_until_done("t6", 300);
        chk("t6_rx_bytes", 32'(rx_bytes_o), 32'd48);
        settle();

        // Asynchronous reset in the middle of a READ burst
        m_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) pc_q.push_back(8'(8'hE0 + i));
        repeat (4) tick();
        chk("t7_pre_reset_read", 32'(rd_n_o), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_oe_n", 32'(oe_n_o), 32'd1);
        chk("t7_rst_rd_n", 32'(rd_n_o), 32'd1);
        chk("t7_rst_bus_rx", 32'(bus_rx_o), 32'd0);
        chk("t7_rst_valid", 32'(m_valid_o), 32'd0);
        chk("t7_rst_count", 32'(fifo_count_o), 32'd0);
        chk("t7_rst_rx_bytes", 32'(rx_bytes_o), 32'd0);
        pc_q.delete();
        exp_q.delete();
        total   = 0;
        prev_oe = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("t7_idle_after", 32'(oe_n_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
